// File: rtl/datamem_ctrl.sv
// Data-memory controller: valid/ready request port in front of a byte-lane block RAM,
// with misaligned accesses either split across two words or reported as faults.
module datamem_ctrl #(
    parameter int ADDR_W      = 16,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault
);
    localparam int WIDX_W = ADDR_W - 2;
    localparam int DEPTH  = 1 << WIDX_W;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                fault_q, fault_d;
    logic                span_q, span_d;
    logic [31:0]         word0_q, word0_d;

    logic                accept;
    logic [2:0]          req_size;
    logic                req_bad_op, req_misaligned, req_fault, req_spans;

    logic [1:0]          lane;
    logic [WIDX_W-1:0]   widx0, widx1;
    logic [3:0]          size_mask;
    logic [63:0]         wide_data;
    logic [7:0]          wide_be;
    logic                ram_en, ram_we;
    logic [WIDX_W-1:0]   ram_addr;
    logic [3:0]          ram_be;
    logic [31:0]         ram_wdata;
    logic [31:0]         ram_rdata;

    logic [63:0]         pair;
    logic [63:0]         shifted;
    logic [31:0]         load_data;

    assign req_ready = (state_q == IDLE) & ~rst;
    assign accept    = req_valid & req_ready;

    // Request decode, evaluated on the live request so the fault/split decision is registered at acceptance
    always_comb begin
        case (req_op[1:0])
            2'b00:   req_size = 3'd4;
            2'b01:   req_size = 3'd1;
            default: req_size = 3'd2;
        endcase
    end

    assign req_bad_op     = (req_op[1:0] == 2'b11) | (req_op == 3'b100);
    assign req_misaligned = ((req_op[1:0] == 2'b10) & req_addr[0]) |
                            ((req_op[1:0] == 2'b00) & (req_addr[1:0] != 2'b00));
    assign req_fault      = req_bad_op | (!MISALIGN_EN & req_misaligned);
    assign req_spans      = ({1'b0, req_addr[1:0]} + req_size) > 3'd4;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fault_d = fault_q;
        span_d  = span_q;
        word0_d = word0_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    fault_d = req_fault;
                    span_d  = MISALIGN_EN & req_spans & ~req_fault;
                    state_d = req_fault ? RESP : ACC0;
                end
            end
            ACC0:    state_d = span_q ? ACC1 : RESP;
            ACC1: begin
                // First word is still sitting in the RAM output register; park it before the second read lands
                word0_d = ram_rdata;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            op_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
            span_q  <= 1'b0;
            word0_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
            span_q  <= span_d;
            word0_q <= word0_d;
        end
    end

    assign lane  = addr_q[1:0];
    assign widx0 = addr_q[ADDR_W-1:2];
    assign widx1 = widx0 + 1'b1;

    always_comb begin
        case (op_q[1:0])
            2'b00:   size_mask = 4'b1111;
            2'b01:   size_mask = 4'b0001;
            default: size_mask = 4'b0011;
        endcase
    end

    // Two-word view of the store: low half targets word0, high half spills into word1
    assign wide_data = {32'h0, wdata_q} << {lane, 3'b000};
    assign wide_be   = {4'b0000, size_mask} << lane;

    assign ram_en    = (state_q == ACC0) | (state_q == ACC1);
    assign ram_we    = ram_en & we_q & ~rst;
    assign ram_addr  = (state_q == ACC1) ? widx1 : widx0;
    assign ram_be    = (state_q == ACC1) ? wide_be[7:4]   : wide_be[3:0];
    assign ram_wdata = (state_q == ACC1) ? wide_data[63:32] : wide_data[31:0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rdata_q;

            always_ff @(posedge clk) begin
                if (ram_en) begin
                    rdata_q <= mem[ram_addr];
                    if (ram_we && ram_be[gi]) begin
                        mem[ram_addr] <= ram_wdata[8*gi +: 8];
                    end
                end
            end

            assign ram_rdata[8*gi +: 8] = rdata_q;
        end
    endgenerate

    assign pair    = span_q ? {ram_rdata, word0_q} : {32'h0, ram_rdata};
    assign shifted = pair >> {lane, 3'b000};

    always_comb begin
        case (op_q[1:0])
            2'b01:   load_data = op_q[2] ? {{24{shifted[7]}}, shifted[7:0]}
                                         : {24'h0, shifted[7:0]};
            2'b10:   load_data = op_q[2] ? {{16{shifted[15]}}, shifted[15:0]}
                                         : {16'h0, shifted[15:0]};
            default: load_data = shifted[31:0];
        endcase
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_fault = rsp_valid & fault_q;
    assign rsp_rdata = (rsp_valid & ~we_q & ~fault_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_datamem_ctrl.sv
// Directed bench for datamem_ctrl: one split-capable instance and one fault-on-misalign instance.
module tb_datamem_ctrl;
    logic        clk;
    logic        rst;
    logic        v1, v0;
    logic        we;
    logic [2:0]  op;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        rdy1, rv1, rf1;
    logic [31:0] rd1;
    logic        rdy0, rv0, rf0;
    logic [31:0] rd0;

    int total = 0;
    int bad   = 0;

    datamem_ctrl #(.ADDR_W(16), .MISALIGN_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(we),
        .req_op(op), .req_addr(addr), .req_wdata(wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_fault(rf1)
    );

    datamem_ctrl #(.ADDR_W(16), .MISALIGN_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(we),
        .req_op(op), .req_addr(addr), .req_wdata(wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_fault(rf0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and measure cycles from the accepting edge to the response pulse
    task automatic do_req(input bit sel, input bit w, input logic [2:0] o,
                          input logic [15:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output logic fault, output int lat);
        bit done;
        we = w; op = o; addr = a; wdata = d;
        if (sel) v0 = 1'b1; else v1 = 1'b1;
        @(posedge clk);
        #1;
        v0 = 1'b0; v1 = 1'b0;
        lat = 0; rdata = 32'h0; fault = 1'b0; done = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (!done) begin
                @(negedge clk);
                if ((sel ? rv0 : rv1) === 1'b1) begin
                    done  = 1'b1;
                    lat   = i;
                    rdata = sel ? rd0 : rd1;
                    fault = sel ? rf0 : rf1;
                end
            end
        end
        $display("req dut%0d we=%0d op=%b addr=%h wdata=%h -> rdata=%h fault=%0d lat=%0d",
                 sel ? 0 : 1, w, o, a, d, rdata, fault, lat);
        if (done) begin
            @(negedge clk);
            total++;
            if ((sel ? rv0 : rv1) !== 1'b0) begin
                bad++;
                $display("FAIL pulse_width: rsp_valid=%b, required 0 one cycle after response", sel ? rv0 : rv1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({rdy1, rdy0, rv1, rf1, rd1} !== {4'b0000, 32'h0}) begin
            bad++;
            $display("FAIL reset_outputs: ready1=%b ready0=%b valid=%b fault=%b rdata=%h, required all 0",
                     rdy1, rdy0, rv1, rf1, rd1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({rdy1, rdy0} !== 2'b11) begin
            bad++;
            $display("FAIL ready_after_reset: ready1=%b ready0=%b, required 1 1", rdy1, rdy0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_aligned();
        logic [31:0] r; logic f; int l;
        do_req(1'b0, 1'b1, 3'b000, 16'h0010, 32'h12345678, r, f, l);
        total++;
        if (l !== 2 || f !== 1'b0 || r !== 32'h0) begin
            bad++; $display("FAIL store_word: lat=%0d fault=%b rdata=%h, required 2 0 00000000", l, f, r);
        end
        do_req(1'b0, 1'b0, 3'b101, 16'h0013, 32'h0, r, f, l);
        total++;
        if (r !== 32'h00000012 || l !== 2) begin
            bad++; $display("FAIL load_bs_13: rdata=%h lat=%0d, required 00000012 2", r, l);
        end
        do_req(1'b0, 1'b0, 3'b110, 16'h0012, 32'h0, r, f, l);
        total++;
        if (r !== 32'h00001234 || l !== 2) begin
            bad++; $display("FAIL load_hs_12: rdata=%h lat=%0d, required 00001234 2", r, l);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] r; logic f; int l;
        do_req(1'b0, 1'b1, 3'b001, 16'h0011, 32'h000000F0, r, f, l);
        do_req(1'b0, 1'b0, 3'b000, 16'h0010, 32'h0, r, f, l);
        total++;
        if (r !== 32'h1234F078) begin
            bad++; $display("FAIL byte_store_word: rdata=%h, required 1234f078", r);
        end
        do_req(1'b0, 1'b0, 3'b101, 16'h0011, 32'h0, r, f, l);
        total++;
        if (r !== 32'hFFFFFFF0) begin
            bad++; $display("FAIL load_bs_11: rdata=%h, required fffffff0", r);
        end
        do_req(1'b0, 1'b0, 3'b001, 16'h0011, 32'h0, r, f, l);
        total++;
        if (r !== 32'h000000F0) begin
            bad++; $display("FAIL load_bu_11: rdata=%h, required 000000f0", r);
        end
    endtask

    task automatic test_split();
        logic [31:0] r; logic f; int l;
        do_req(1'b0, 1'b1, 3'b000, 16'h0014, 32'h0, r, f, l);
        do_req(1'b0, 1'b1, 3'b000, 16'h0018, 32'h0, r, f, l);
        do_req(1'b0, 1'b1, 3'b000, 16'h0016, 32'hAABBCCDD, r, f, l);
        total++;
        if (l !== 3 || f !== 1'b0) begin
            bad++; $display("FAIL split_store_lat: lat=%0d fault=%b, required 3 0", l, f);
        end
        do_req(1'b0, 1'b0, 3'b000, 16'h0014, 32'h0, r, f, l);
        total++;
        if (r !== 32'hCCDD0000) begin
            bad++; $display("FAIL split_word0: rdata=%h, required ccdd0000", r);
        end
        do_req(1'b0, 1'b0, 3'b000, 16'h0018, 32'h0, r, f, l);
        total++;
        if (r !== 32'h0000AABB) begin
            bad++; $display("FAIL split_word1: rdata=%h, required 0000aabb", r);
        end
        do_req(1'b0, 1'b0, 3'b000, 16'h0016, 32'h0, r, f, l);
        total++;
        if (r !== 32'hAABBCCDD || l !== 3) begin
            bad++; $display("FAIL split_load: rdata=%h lat=%0d, required aabbccdd 3", r, l);
        end
        do_req(1'b0, 1'b0, 3'b010, 16'h0015, 32'h0, r, f, l);
        total++;
        if (r !== 32'h0000DD00 || l !== 2 || f !== 1'b0) begin
            bad++; $display("FAIL misaligned_half_in_word: rdata=%h lat=%0d fault=%b, required 0000dd00 2 0", r, l, f);
        end
    endtask

    task automatic test_faults();
        logic [31:0] r; logic f; int l;
        do_req(1'b1, 1'b1, 3'b000, 16'h0000, 32'hCAFEF00D, r, f, l);
        do_req(1'b1, 1'b0, 3'b000, 16'h0002, 32'h0, r, f, l);
        total++;
        if (f !== 1'b1 || r !== 32'h0 || l !== 1) begin
            bad++; $display("FAIL misalign_fault: fault=%b rdata=%h lat=%0d, required 1 00000000 1", f, r, l);
        end
        do_req(1'b1, 1'b1, 3'b011, 16'h0000, 32'hFFFFFFFF, r, f, l);
        total++;
        if (f !== 1'b1 || l !== 1) begin
            bad++; $display("FAIL badop_011: fault=%b lat=%0d, required 1 1", f, l);
        end
        do_req(1'b1, 1'b1, 3'b000, 16'h0002, 32'h55555555, r, f, l);
        total++;
        if (f !== 1'b1 || l !== 1) begin
            bad++; $display("FAIL misalign_store_fault: fault=%b lat=%0d, required 1 1", f, l);
        end
        do_req(1'b1, 1'b0, 3'b000, 16'h0000, 32'h0, r, f, l);
        total++;
        if (r !== 32'hCAFEF00D || f !== 1'b0) begin
            bad++; $display("FAIL mem_unchanged: rdata=%h fault=%b, required cafef00d 0", r, f);
        end
        do_req(1'b0, 1'b0, 3'b100, 16'h0010, 32'h0, r, f, l);
        total++;
        if (f !== 1'b1 || r !== 32'h0 || l !== 1) begin
            bad++; $display("FAIL badop_100: fault=%b rdata=%h lat=%0d, required 1 00000000 1", f, r, l);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] r; logic f; int l;
        do_req(1'b0, 1'b1, 3'b000, 16'hFFFE, 32'h11223344, r, f, l);
        do_req(1'b0, 1'b0, 3'b010, 16'hFFFE, 32'h0, r, f, l);
        total++;
        if (r !== 32'h00003344) begin
            bad++; $display("FAIL wrap_half_top: rdata=%h, required 00003344", r);
        end
        do_req(1'b0, 1'b0, 3'b010, 16'h0000, 32'h0, r, f, l);
        total++;
        if (r !== 32'h00001122) begin
            bad++; $display("FAIL wrap_half_zero: rdata=%h, required 00001122", r);
        end
        do_req(1'b0, 1'b0, 3'b000, 16'hFFFE, 32'h0, r, f, l);
        total++;
        if (r !== 32'h11223344 || l !== 3) begin
            bad++; $display("FAIL wrap_word: rdata=%h lat=%0d, required 11223344 3", r, l);
        end
    endtask

    task automatic test_reset_mid_split();
        logic [31:0] r; logic f; int l;
        bit seen;
        do_req(1'b0, 1'b1, 3'b000, 16'h0014, 32'h0, r, f, l);
        do_req(1'b0, 1'b1, 3'b000, 16'h0018, 32'h0, r, f, l);
        we = 1'b1; op = 3'b000; addr = 16'h0016; wdata = 32'hAABBCCDD; v1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        seen = seen | rv1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        seen = seen | rv1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        seen = seen | rv1;
        $display("req dut1 split store aabbccdd @0016 with reset in second access");
        total++;
        if (seen !== 1'b0 || rdy1 !== 1'b1) begin
            bad++; $display("FAIL reset_mid_split: saw_valid=%b ready=%b, required 0 1", seen, rdy1);
        end
        @(posedge clk);
        #1;
        do_req(1'b0, 1'b0, 3'b000, 16'h0014, 32'h0, r, f, l);
        total++;
        if (r !== 32'hCCDD0000) begin
            bad++; $display("FAIL reset_first_half: rdata=%h, required ccdd0000", r);
        end
        do_req(1'b0, 1'b0, 3'b000, 16'h0018, 32'h0, r, f, l);
        total++;
        if (r !== 32'h00000000) begin
            bad++; $display("FAIL reset_second_half: rdata=%h, required 00000000", r);
        end
    endtask

    initial begin
        rst = 1'b1; v1 = 1'b0; v0 = 1'b0; we = 1'b0; op = 3'b000;
        addr = 16'h0; wdata = 32'h0;
        test_reset();
        test_aligned();
        test_byte_lanes();
        test_split();
        test_faults();
        test_wrap();
        test_reset_mid_split();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/datamem_ctrl.md
# datamem_ctrl

Parametrised data-memory controller for the single-cycle and multi-cycle CPU labs. It is the successor to the fixed 64 KiB word RAM and adds a configurable depth, true byte-lane writes, and a valid/ready request port with a one-cycle response pulse. It also handles misaligned accesses, either by splitting them into two word accesses or by raising a fault. It sits between the CPU load/store unit and a block-RAM array of `2**(ADDR_W-2)` 32-bit words.

## Interface
- `ADDR_W`, 16, byte-address width; the array holds `2**(ADDR_W-2)` words.
- `MISALIGN_EN`, 1, 1: split word-spanning accesses into two word accesses; 0: fault on any naturally misaligned access.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_op`  in  3  MemOp: 000 word; 001 byte unsigned; 010 half unsigned; 101 byte signed; 110 half signed. For stores, 001/101 mean byte and 010/110 mean half.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `rsp_rdata`  out  32  load result; 0 for stores and faults.
- `rsp_fault`  out  1  qualified by `rsp_valid`; 1 means bad MemOp or misalignment, with no memory access.

## Operation
- Byte order is little-endian. Byte k of a word is `[8k+7:8k]`. Word index = `addr[ADDR_W-1:2]`, lane = `addr[1:0]`.
- The array has 4 byte write-enables. Sub-word stores write only their lanes; there is no read-modify-write.
- Accept a request when `req_valid & req_ready`. All request fields are registered at acceptance.
- Size is 1, 2 or 4 bytes. An access spans two words when `lane + size > 4`.
- Natural misalignment: half with `addr[0]=1`, or word with `addr[1:0]!=0`.
  - With `MISALIGN_EN=0`, a naturally misaligned access faults.
  - With `MISALIGN_EN=1`, a misaligned access that stays within one word completes as one access; a spanning access is split into two.
- MemOp 011, 100 or 111 faults.
- Second word index = first + 1, modulo depth (wraps to 0).
- FSM states: IDLE, ACC0, ACC1, RESP.
  - IDLE → RESP on a faulting request.
  - IDLE → ACC0 otherwise.
  - ACC0 → ACC1 if the access spans two words, else ACC0 → RESP.
  - ACC1 → RESP.
  - RESP → IDLE.
- ACC0 issues the RAM read or write for the first word; ACC1 does the same for the second word.
- Load assembly:
  - Concatenate {word1, word0} and shift right by `8*lane`.
  - Take the low `size` bytes, then zero- or sign-extend per `req_op`.
  - `rsp_rdata` is registered and valid in RESP.
- Store split: the low `4-lane` bytes go to word0 at lanes `lane..3`; the remaining bytes go to word1 at lanes `0..`.

## Timing
- Reset values: state IDLE, `req_ready=0` during the reset cycle and 1 from the first cycle after, `rsp_valid=0`, `rsp_rdata=0`, `rsp_fault=0`.
- RAM contents are not reset.
- Acceptance in cycle n gives `rsp_valid` in:
  - n+1 for a fault;
  - n+2 for a single-word access;
  - n+3 for a two-word access.
- `rsp_valid` is high for exactly one cycle.
- The earliest next acceptance is in the cycle after RESP. Throughput is one request per 3 cycles (aligned) or 4 cycles (split).
- The RAM read is synchronous with 1-cycle latency. The read issued in ACC0 is captured at the ACC0→next edge. A store is committed at the edge leaving ACC0 or ACC1.
- `req_*` inputs are ignored while `req_ready=0`.
- Reset mid-operation:
  - The FSM returns to IDLE and no response is produced.
  - A committed first half of a split store remains; the second half is not written.
- There is no read/write hazard, because only one request is in flight at a time.

## Test plan
- Store word 0x12345678 @0x0010, then load byte-signed @0x0013 → 0x00000012; load half-signed @0x0012 → 0x00001234; each `rsp_valid` at n+2.
- Store byte 0xF0 @0x0011, then load word @0x0010 → 0x1234F078; load byte-signed @0x0011 → 0xFFFFFFF0; load byte-unsigned @0x0011 → 0x000000F0.
- With `MISALIGN_EN=1`: zero words @0x14 and @0x18, store word 0xAABBCCDD @0x0016 (`rsp_valid` at n+3). Load @0x14 → 0xCCDD0000, load @0x18 → 0x0000AABB, and load word @0x0016 → 0xAABBCCDD at n+3.
- With `MISALIGN_EN=0`, load word @0x0002 → `rsp_fault=1`, `rsp_rdata=0` at n+1. MemOp 011 on an aligned address → fault. Memory is unchanged in both cases.
- With `ADDR_W=16`, store word 0x11223344 @0xFFFE: load half @0xFFFE → 0x3344, load half-unsigned @0x0000 → 0x1122.
- Split store 0xAABBCCDD @0x0016, assert `rst` during ACC1: no `rsp_valid`, `req_ready=1` after reset, word @0x14 updated, word @0x18 unchanged.
